// File: rtl/engine_pkg.sv
// engine_pkg: shared widths, burst lengths, op codes and writeback FSM states
package engine_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 30;
    localparam int CONV_BURST_LEN = 16;
    localparam int POOL_BURST_LEN = 1;
    typedef enum logic [2:0] {OP_CONV = 3'd1, OP_MPOOL = 3'd4, OP_APOOL = 3'd5} op_type_e;
    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_STREAM, ST_DONE} wb_state_e;
endpackage

// File: rtl/wb_slot_buf.sv
// wb_slot_buf: two-slot ping-pong burst storage with per-slot full flags
module wb_slot_buf #(
    parameter int BURST_LEN = 16,
    parameter int DATA_W = 16,
    parameter int IDX_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic                          wr_sel,
    input  logic [BURST_LEN*DATA_W-1:0]   wr_data,
    input  logic                          clr_en,
    input  logic                          clr_sel,
    input  logic                          rd_sel,
    input  logic [IDX_W-1:0]              rd_idx,
    output logic [DATA_W-1:0]             rd_data,
    output logic [1:0]                    full
);
    logic [1:0][BURST_LEN*DATA_W-1:0] mem_q, mem_d;
    logic [1:0] full_q, full_d;
    always_comb begin
        mem_d = mem_q;
        full_d = full_q;
        if (clr_en) full_d[clr_sel] = 1'b0;
        if (wr_en) begin
            mem_d[wr_sel] = wr_data;
            full_d[wr_sel] = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        full_q <= rst ? 2'b00 : full_d;
    end
    assign rd_data = mem_q[rd_sel][int'(rd_idx)*DATA_W +: DATA_W];
    assign full = full_q;
endmodule

// File: rtl/wb_serializer.sv
// wb_serializer: captures result bursts into a ping-pong buffer and streams them to the DMA write FIFO
module wb_serializer #(
    parameter int BURST_LEN = engine_pkg::CONV_BURST_LEN,
    parameter int DATA_W = engine_pkg::DATA_W,
    parameter int ADDR_W = engine_pkg::ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic                          base_load,
    input  logic                          res_valid,
    input  logic [BURST_LEN*DATA_W-1:0]   res_data,
    output logic                          res_ready,
    output logic                          dma_writes_en,
    output logic [ADDR_W-1:0]             dma_addr,
    input  logic                          dma_ib_re,
    output logic [DATA_W-1:0]             dma_ib_data,
    output logic                          dma_ib_valid,
    output logic                          burst_done,
    output logic                          busy
);
    import engine_pkg::*;
    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam int IDX_W = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);
    wb_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d, rd_data;
    logic we_q, we_d, valid_q, valid_d, wsel_q, wsel_d, rsel_q, rsel_d;
    logic capture, clr_en;
    logic [1:0] full;
    assign capture = res_valid && res_ready;
    assign res_ready = !(full[0] && full[1]);
    assign busy = (|full) || (state_q != ST_IDLE);
    wb_slot_buf #(
        .BURST_LEN(BURST_LEN),
        .DATA_W(DATA_W),
        .IDX_W(IDX_W)
    ) u_slot_buf (
        .clk(clk),
        .rst(rst),
        .wr_en(capture),
        .wr_sel(wsel_q),
        .wr_data(res_data),
        .clr_en(clr_en),
        .clr_sel(rsel_q),
        .rd_sel(rsel_q),
        .rd_idx(cnt_q[IDX_W-1:0]),
        .rd_data(rd_data),
        .full(full)
    );
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        wr_ptr_d = (base_load && !busy) ? base_addr : wr_ptr_q;
        addr_d = addr_q;
        we_d = we_q;
        data_d = data_q;
        valid_d = 1'b0;
        wsel_d = wsel_q ^ capture;
        rsel_d = rsel_q;
        clr_en = 1'b0;
        case (state_q)
            ST_IDLE: if (full[rsel_q]) begin
                state_d = ST_ARM;
                addr_d = wr_ptr_q;
                we_d = 1'b1;
            end
            ST_ARM: begin
                state_d = ST_STREAM;
                cnt_d = '0;
            end
            ST_STREAM: if (dma_ib_re) begin
                data_d = rd_data;
                valid_d = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    we_d = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                clr_en = 1'b1;
                rsel_d = !rsel_q;
                wr_ptr_d = wr_ptr_q + ADDR_W'(BURST_LEN);
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q <= '0;
            wr_ptr_q <= '0;
            addr_q <= '0;
            we_q <= 1'b0;
            data_q <= '0;
            valid_q <= 1'b0;
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            addr_q <= addr_d;
            we_q <= we_d;
            data_q <= data_d;
            valid_q <= valid_d;
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
        end
    end
    assign dma_writes_en = we_q;
    assign dma_addr = addr_q;
    assign dma_ib_data = data_q;
    assign dma_ib_valid = valid_q;
    assign burst_done = state_q == ST_DONE;
endmodule

// File: tb/tb_wb_serializer.sv
// tb_wb_serializer: scoreboard bench for the writeback serializer
module tb_wb_serializer;
    logic clk = 1'b0;
    logic rst, base_load, res_valid, dma_ib_re;
    logic [29:0] base_addr;
    logic [255:0] res_data;
    logic res_ready, dma_writes_en, dma_ib_valid, burst_done, busy;
    logic [29:0] dma_addr;
    logic [15:0] dma_ib_data;
    logic [15:0] exp_data_q[$];
    logic [29:0] exp_addr_q[$];
    logic [29:0] model_ptr, cur_addr;
    logic we_prev;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    wb_serializer dut (
        .clk(clk),
        .rst(rst),
        .base_addr(base_addr),
        .base_load(base_load),
        .res_valid(res_valid),
        .res_data(res_data),
        .res_ready(res_ready),
        .dma_writes_en(dma_writes_en),
        .dma_addr(dma_addr),
        .dma_ib_re(dma_ib_re),
        .dma_ib_data(dma_ib_data),
        .dma_ib_valid(dma_ib_valid),
        .burst_done(burst_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            we_prev = 1'b0;
        end else begin
            if (dma_ib_valid) begin
                chk("sb_word_pending", 64'(exp_data_q.size() != 0), 64'(1));
                if (exp_data_q.size() != 0) chk("word", 64'(dma_ib_data), 64'(exp_data_q.pop_front()));
            end
            if (dma_writes_en && !we_prev) begin
                chk("sb_addr_pending", 64'(exp_addr_q.size() != 0), 64'(1));
                if (exp_addr_q.size() != 0) chk("addr", 64'(dma_addr), 64'(exp_addr_q.pop_front()));
                cur_addr = dma_addr;
            end else if (dma_writes_en) begin
                chk("addr_stable", 64'(dma_addr), 64'(cur_addr));
            end
            we_prev = dma_writes_en;
            if (burst_done) done_cnt++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(res_ready), 64'(1));
        chk({tag, "_we"}, 64'(dma_writes_en), 64'(0));
        chk({tag, "_addr"}, 64'(dma_addr), 64'(0));
        chk({tag, "_data"}, 64'(dma_ib_data), 64'(0));
        chk({tag, "_valid"}, 64'(dma_ib_valid), 64'(0));
        chk({tag, "_done"}, 64'(burst_done), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    task automatic load_base(input logic [29:0] a, input logic taken);
        chk("busy_at_load", 64'(busy), 64'(!taken));
        base_addr = a;
        base_load = 1'b1;
        if (taken) model_ptr = a;
        tick();
        base_load = 1'b0;
    endtask

    task automatic send(input logic [15:0] w0);
        for (int t = 0; t < 200 && !res_ready; t++) tick();
        chk("ready_wait", 64'(res_ready), 64'(1));
        for (int k = 0; k < 16; k++) begin
            res_data[k*16 +: 16] = w0 + 16'(k);
            exp_data_q.push_back(w0 + 16'(k));
        end
        exp_addr_q.push_back(model_ptr);
        model_ptr = model_ptr + 30'd16;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic wait_idle(input int exp_done);
        for (int t = 0; t < 500 && (busy || exp_data_q.size() != 0); t++) tick();
        chk("idle", 64'(busy), 64'(0));
        chk("done_cnt", 64'(done_cnt), 64'(exp_done));
    endtask

    task automatic wait_first_valid();
        int t = 0;
        @(negedge clk);
        while (!dma_ib_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("first_valid", 64'(dma_ib_valid), 64'(1));
    endtask

    task automatic stream_run();
        wait_first_valid();
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            chk("consec_valid", 64'(dma_ib_valid), 64'(1));
        end
        chk("done_on_last", 64'(burst_done), 64'(1));
        @(negedge clk);
        chk("valid_after_last", 64'(dma_ib_valid), 64'(0));
        chk("done_single", 64'(burst_done), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] last;
        int t;
        rst = 1'b1;
        base_load = 1'b0;
        res_valid = 1'b0;
        dma_ib_re = 1'b0;
        base_addr = '0;
        res_data = '0;
        model_ptr = '0;
        cur_addr = '0;
        tick(3);
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();
        dma_ib_re = 1'b1;
        load_base(30'h100, 1'b1);
        send(16'h3C00);
        stream_run();
        wait_idle(1);
        send(16'h4000);
        wait_idle(2);
        load_base(30'h100, 1'b1);
        send(16'h1000);
        send(16'h2000);
        chk("ready_both_full", 64'(res_ready), 64'(0));
        t = 0;
        @(negedge clk);
        while (!burst_done && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("first_done_seen", 64'(burst_done), 64'(1));
        @(negedge clk);
        chk("ready_back", 64'(res_ready), 64'(1));
        @(posedge clk);
        #1;
        wait_idle(4);
        dma_ib_re = 1'b0;
        send(16'h5000);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!dma_writes_en && t < 50);
        chk("arm_seen", 64'(dma_writes_en), 64'(1));
        @(posedge clk);
        #1;
        last = '0;
        for (int i = 0; i < 32; i++) begin
            dma_ib_re = (i % 2 == 0);
            tick();
            chk("re_latency", 64'(dma_ib_valid), 64'(i % 2 == 0));
            if (!dma_ib_valid) chk("data_hold", 64'(dma_ib_data), 64'(last));
            last = dma_ib_data;
        end
        wait_idle(5);
        dma_ib_re = 1'b1;
        load_base(30'h3FFFFFF8, 1'b1);
        send(16'h6000);
        send(16'h7000);
        wait_idle(7);
        send(16'h8000);
        wait_first_valid();
        repeat (7) @(negedge clk);
        chk("word7_valid", 64'(dma_ib_valid), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;
        exp_data_q.delete();
        exp_addr_q.delete();
        model_ptr = '0;
        tick(3);
        chk("no_done_on_rst", 64'(done_cnt), 64'(7));
        send(16'h9000);
        wait_idle(8);
        send(16'hA000);
        load_base(30'h500, 1'b0);
        wait_idle(9);
        send(16'hB000);
        wait_idle(10);
        load_base(30'h500, 1'b1);
        send(16'hC000);
        wait_idle(11);
        chk("sb_data_empty", 64'(exp_data_q.size()), 64'(0));
        chk("sb_addr_empty", 64'(exp_addr_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
